// File: rtl/fpaddsub_align_sched.sv
// Alignment-shift scheduler for the FP add/sub datapath.
// One right-shifter is shared round-robin between requesters A and B. The smaller-operand
// mantissa (hidden bit prepended) is shifted right by at most STEP bits per cycle, and the
// result is returned with a requester tag over a valid/ready handshake.
// Optional: define FPADDSUB_ALIGN_STICKY_EN to build the sticky-bit accumulator; without it
// out_sticky is tied low.
module fpaddsub_align_sched #(
  parameter int unsigned MANT_W  = 23,
  parameter int unsigned SHIFT_W = 5,
  parameter int unsigned STEP    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                a_valid,
  output logic                a_ready,
  input  logic [MANT_W-1:0]   a_mant,
  input  logic [SHIFT_W-1:0]  a_shift,
  input  logic                b_valid,
  output logic                b_ready,
  input  logic [MANT_W-1:0]   b_mant,
  input  logic [SHIFT_W-1:0]  b_shift,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [MANT_W:0]     out_mant,
  output logic                out_sticky,
  output logic                out_tag
);

  localparam int unsigned W = MANT_W + 1;
  localparam logic [SHIFT_W-1:0] STEP_N = SHIFT_W'(STEP);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_t;

  state_t             state;
  logic [W-1:0]       mant_r;
  logic [SHIFT_W-1:0] rem;
  logic               tag_r;
  logic               last_grant;  // 0 = A, 1 = B
  logic               out_valid_r;

  logic               idle;
  logic               acc;
  logic               sel_b;
  logic [MANT_W-1:0]  sel_mant;
  logic [SHIFT_W-1:0] sel_shift;
  logic               sel_zero;
  logic               sel_sat;
  logic [SHIFT_W-1:0] n;
  logic [W-1:0]       shifted;

  // Round-robin grant; readies stay low while reset is asserted.
  always_comb begin
    idle    = rst && (state == StIdle);
    a_ready = idle && a_valid && (!b_valid || last_grant);
    b_ready = idle && b_valid && (!a_valid || !last_grant);
  end

  // Operand select and per-cycle shift amount.
  always_comb begin
    acc       = a_ready || b_ready;
    sel_b     = b_ready;
    sel_mant  = sel_b ? b_mant : a_mant;
    sel_shift = sel_b ? b_shift : a_shift;
    sel_zero  = (sel_shift == '0);
    sel_sat   = (32'(sel_shift) >= W);
    n         = (32'(rem) > STEP) ? STEP_N : rem;
    shifted   = mant_r >> n;
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= StIdle;
      mant_r      <= '0;
      rem         <= '0;
      tag_r       <= 1'b0;
      last_grant  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          if (acc) begin
            tag_r      <= sel_b;
            last_grant <= sel_b;
            rem        <= sel_shift;
            if (sel_zero) begin
              mant_r      <= {1'b1, sel_mant};
              state       <= StDone;
              out_valid_r <= 1'b1;
            end else if (sel_sat) begin
              // Everything shifts out: finish in one cycle with a zero mantissa.
              mant_r      <= '0;
              rem         <= '0;
              state       <= StDone;
              out_valid_r <= 1'b1;
            end else begin
              mant_r <= {1'b1, sel_mant};
              state  <= StShift;
            end
          end
        end
        StShift: begin
          mant_r <= shifted;
          rem    <= rem - n;
          if (rem == n) begin
            state       <= StDone;
            out_valid_r <= 1'b1;
          end
        end
        StDone: begin
          if (out_ready) begin
            state       <= StIdle;
            out_valid_r <= 1'b0;
          end
        end
        default: begin
          state       <= StIdle;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

`ifdef FPADDSUB_ALIGN_STICKY_EN
  logic sticky_r;
  logic lost;

  // Bits that fall off the bottom during this cycle's shift.
  always_comb begin
    lost = |(mant_r & ~({W{1'b1}} << n));
  end

  // Sticky accumulator: cleared on accept (set on saturation), OR-ed during shifts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sticky_r <= 1'b0;
    end else if (acc) begin
      sticky_r <= sel_sat;
    end else if (state == StShift) begin
      sticky_r <= sticky_r | lost;
    end
  end

  assign out_sticky = sticky_r;
`else
  assign out_sticky = 1'b0;
`endif

  assign out_valid = out_valid_r;
  assign out_mant  = mant_r;
  assign out_tag   = tag_r;

endmodule

// File: tb/tb_fpaddsub_align_sched.sv
// Directed scoreboard bench for fpaddsub_align_sched (default parameters).
module tb_fpaddsub_align_sched;

  localparam int STEP = 8;

  logic        clk;
  logic        rst;
  logic        a_valid, a_ready, b_valid, b_ready;
  logic [22:0] a_mant, b_mant;
  logic [4:0]  a_shift, b_shift;
  logic        out_valid, out_ready, out_sticky, out_tag;
  logic [23:0] out_mant;

  fpaddsub_align_sched dut (
    .clk       (clk),
    .rst       (rst),
    .a_valid   (a_valid),
    .a_ready   (a_ready),
    .a_mant    (a_mant),
    .a_shift   (a_shift),
    .b_valid   (b_valid),
    .b_ready   (b_ready),
    .b_mant    (b_mant),
    .b_shift   (b_shift),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_mant  (out_mant),
    .out_sticky(out_sticky),
    .out_tag   (out_tag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] mant;
    logic        sticky;
    logic        tag;
    int          lat;
    int          acc_c;
  } exp_t;

  exp_t sb[$];
  logic got_tags[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  logic prev_ov = 1'b0;
  logic tb_last = 1'b1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Closed-form reference: full shift in one go, no stepping.
  function automatic exp_t model(input logic [22:0] m, input logic [4:0] s, input logic t,
                                 input int c);
    exp_t r;
    logic [23:0] f;
    f       = {1'b1, m};
    r.tag   = t;
    r.acc_c = c;
    if (s == 0) begin
      r.mant = f; r.sticky = 1'b0; r.lat = 1;
    end else if (int'(s) >= 24) begin
      r.mant = '0; r.sticky = 1'b1; r.lat = 1;
    end else begin
      r.mant   = f >> s;
      r.sticky = |(f & ((24'h1 << s) - 24'h1));
      r.lat    = 1 + (int'(s) + STEP - 1) / STEP;
    end
`ifndef FPADDSUB_ALIGN_STICKY_EN
    r.sticky = 1'b0;
`endif
    return r;
  endfunction

  // Observe at negedge+1, update scoreboard, then advance one full cycle.
  task automatic tick();
    exp_t e;
    #1;
    check("ready_onehot", 32'(a_ready && b_ready), 0);
    if (out_valid) begin
      check("done_noready", {30'b0, a_ready, b_ready}, 0);
      if (sb.size() == 0) begin
        check("unexpected_out", 32'(out_valid), 0);
      end else begin
        e = sb[0];
        check("out_mant", 32'(out_mant), 32'(e.mant));
        check("out_sticky", 32'(out_sticky), 32'(e.sticky));
        check("out_tag", 32'(out_tag), 32'(e.tag));
        if (!prev_ov) check("latency", cyc - e.acc_c, e.lat);
        if (out_ready) begin
          got_tags.push_back(e.tag);
          void'(sb.pop_front());
        end
      end
    end
    if (a_valid && b_valid && (a_ready || b_ready))
      check("rr_grant", 32'(b_ready), 32'(!tb_last));
    if (a_valid && a_ready) begin
      sb.push_back(model(a_mant, a_shift, 1'b0, cyc));
      tb_last = 1'b0;
    end
    if (b_valid && b_ready) begin
      sb.push_back(model(b_mant, b_shift, 1'b1, cyc));
      tb_last = 1'b1;
    end
    prev_ov = out_valid;
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic wait_empty(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check("drain_timeout", sb.size(), 0);
  endtask

  initial begin
    clk = 1'b0; rst = 1'b0; out_ready = 1'b1;
    a_valid = 1'b1; a_mant = '0; a_shift = '0;
    b_valid = 1'b1; b_mant = '0; b_shift = '0;

    // Reset state
    #12;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_mant", 32'(out_mant), 0);
    check("rst_out_sticky", 32'(out_sticky), 0);
    check("rst_out_tag", 32'(out_tag), 0);
    check("rst_readies", {30'b0, a_ready, b_ready}, 0);
    @(negedge clk);
    rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0;

    // A only, shift 4; inputs changed after accept must not matter
    a_valid = 1'b1; a_mant = 23'h400001; a_shift = 5'd4;
    tick();
    a_valid = 1'b0; a_mant = 23'h7fffff; a_shift = 5'd31;
    wait_empty(20);

    // A only, shift 20 in three steps; block must be back in IDLE already
    a_valid = 1'b1; a_mant = 23'h0; a_shift = 5'd20;
    #1 check("idle_ready", 32'(a_ready), 1);
    tick();
    a_valid = 1'b0;
    wait_empty(20);

    // B only, shift 0
    b_valid = 1'b1; b_mant = 23'h123456; b_shift = 5'd0;
    tick();
    b_valid = 1'b0;
    wait_empty(20);

    // A only, saturation
    a_valid = 1'b1; a_mant = 23'h55aa55; a_shift = 5'd30;
    tick();
    a_valid = 1'b0;
    wait_empty(20);

    // After reset, both valid held: grants alternate starting with A
    rst = 1'b0; #1; rst = 1'b1;
    tb_last = 1'b1; prev_ov = 1'b0;
    got_tags.delete();
    a_valid = 1'b1; a_mant = 23'h0f0f0f; a_shift = 5'd9;
    b_valid = 1'b1; b_mant = 23'h3c3c3c; b_shift = 5'd2;
    for (int i = 0; i < 100 && got_tags.size() < 4; i++) tick();
    a_valid = 1'b0; b_valid = 1'b0;
    wait_empty(20);
    check("alt_count", 32'(got_tags.size() >= 4), 1);
    for (int i = 0; i < 4 && i < got_tags.size(); i++)
      check("alt_tag", 32'(got_tags[i]), i % 2);

    // Reset in the second SHIFT cycle discards the operation and restores the pointer
    a_valid = 1'b1; a_mant = 23'h001234; a_shift = 5'd20;
    tick();
    a_valid = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 0);
    sb.delete(); tb_last = 1'b1; prev_ov = 1'b0;
    tick();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("postrst_out_valid", 32'(out_valid), 0);
    end
    a_valid = 1'b1; b_valid = 1'b1;
    #1 check("postrst_grant", {30'b0, a_ready, b_ready}, 32'h2);
    tick();
    a_valid = 1'b0; b_valid = 1'b0;
    wait_empty(20);

    // Backpressure: outputs held in DONE, no readies, completes on out_ready
    a_valid = 1'b1; a_mant = 23'h2aaaaa; a_shift = 5'd3; out_ready = 1'b0;
    tick();
    a_valid = 1'b0;
    begin
      int n = 0;
      while (!out_valid && n < 10) begin
        tick();
        n++;
      end
    end
    check("bp_reach", 32'(out_valid), 1);
    a_valid = 1'b1; b_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_valid", 32'(out_valid), 1);
    end
    a_valid = 1'b0; b_valid = 1'b0;
    out_ready = 1'b1;
    wait_empty(5);
    #1 check("bp_idle", 32'(out_valid), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fpaddsub_align_sched.md
Name: fpaddsub_align_sched

Overview:
- Iterative alignment-shift scheduler for the FP add/sub datapath.
- Shares one right-shifter between two requesters, A and B, e.g. two adder lanes.
- Each requester supplies a smaller-operand mantissa (hidden bit implicit) and an exponent difference.
- The block arbitrates round-robin, shifts the mantissa right by at most STEP bits per cycle until aligned, collects a sticky bit, and returns the result tagged with the requester id over a valid/ready handshake.

Parameters:
- MANT_W, 23: stored mantissa width; the internal and result width is MANT_W+1 (hidden bit prepended as 1).
- SHIFT_W, 5: width of the shift-amount inputs.
- STEP, 8: maximum right shift per SHIFT cycle; 1..16.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- a_valid  input  1  requester A has an operand.
- a_ready  output  1  A accepted this cycle when a_valid && a_ready.
- a_mant  input  MANT_W  A mantissa, hidden bit excluded.
- a_shift  input  SHIFT_W  A right-shift amount.
- b_valid, b_ready, b_mant, b_shift: same as A, for requester B.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- out_mant  output  MANT_W+1  aligned mantissa.
- out_sticky  output  1  OR of all bits shifted out.
- out_tag  output  1  0 = result belongs to A, 1 = result belongs to B.

Behaviour:
- Reset (rst low, asynchronous):
  - state=IDLE; out_valid=0, out_mant=0, out_sticky=0, out_tag=0.
  - a_ready=b_ready=0 while rst is low.
  - Round-robin pointer last_grant=B, so A wins the first tie.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - Ready is combinational. Only A valid: a_ready=1. Only B valid: b_ready=1.
  - Both valid: grant the requester not equal to last_grant. Exactly one ready is high at a time.
  - On handshake: mant_r={1'b1,x_mant}, rem=x_shift, sticky_r=0, tag_r=requester id, last_grant=requester.
  - Next state:
    - x_shift==0: DONE, mant unchanged.
    - x_shift>=MANT_W+1: DONE, mant_r=0, sticky_r=1 (saturation, single cycle).
    - Otherwise: SHIFT.
- SHIFT:
  - Both readies are 0.
  - Each cycle: n=min(rem,STEP); mant_r>>=n; sticky_r|= OR of the n bits shifted out; rem-=n.
  - When the new rem==0, go to DONE.
- DONE:
  - out_valid=1; out_mant/out_sticky/out_tag driven from registers and held stable until out_ready.
  - On out_valid && out_ready, go to IDLE next cycle.
  - No new accept occurs in DONE; minimum cycle per operation is accept, then shifts, then DONE.
- Latency, accept edge = cycle T:
  - out_valid rises at T+1 for shift 0 or saturation.
  - Otherwise out_valid rises at T+1+ceil(shift/STEP).
- Throughput: one result per (latency+1) cycles with out_ready held high.
- Inputs are sampled only at the handshake; later changes to x_mant/x_shift do not affect an in-flight operation.
- A requester that drops valid before being granted is simply not served; the pointer is unchanged.
- Reset mid-operation: any state returns to IDLE asynchronously, the in-flight result is discarded, out_valid=0 immediately, and the pointer is restored.
- Outputs out_mant/out_sticky/out_tag are registered; ready signals are combinational from state and valids.

Optional Feature:
- FPADDSUB_ALIGN_STICKY_EN
- Defined: sticky accumulation as described above.
- Undefined: no sticky logic is generated; out_sticky is tied 0, including on saturation. out_mant and timing are unchanged.

Test Plan:
- A only, a_mant=23'h400001, a_shift=4, out_ready=1 → accepted at T; out_valid at T+2; out_mant=24'h0C0000, out_sticky=1, out_tag=0; back to IDLE at T+3.
- A only, a_mant=0, a_shift=20, STEP=8 → three SHIFT cycles (8,8,4); out_valid at T+4; out_mant=24'h000008, out_sticky=0.
- B only, b_shift=0, b_mant=23'h123456 → out_valid at T+1; out_mant=24'h923456, out_sticky=0, out_tag=1.
- A only, a_shift=30, any mantissa → saturation; out_valid at T+1; out_mant=0; out_sticky=1 with the macro, 0 without.
- After reset, a_valid=b_valid=1 held continuously → grants alternate A, B, A, B; out_tag sequence 0,1,0,1; a_ready and b_ready never high together.
- a_shift=20 accepted, then rst pulsed low during the second SHIFT cycle, then released → out_valid=0 throughout; next simultaneous request grants A first.
- Additional check (backpressure): out_ready=0 for 5 cycles in DONE → out_valid and outputs stable; no ready asserted; completion on the first out_ready=1.
